rotate_seq_ctrl: RTL and testbench



---
 rtl/rotate_seq_ctrl_pkg.sv | 20 ++
 rtl/rotate_seq_ctrl_if.sv | 28 ++
 rtl/rotate_seq_ctrl_core.sv | 30 +++
 rtl/rotate_seq_ctrl.sv | 90 +++++++++
 tb/tb_rotate_seq_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/rotate_seq_ctrl_pkg.sv
// Shared types and constants for the rotate sequencer and its rotator core.
package rotate_pkg;

    localparam int WIDTH_DEF = 100;
    localparam int CNT_W_DEF = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    localparam logic [1:0] ENA_HOLD  = 2'b00;
    localparam logic [1:0] ENA_RIGHT = 2'b01;
    localparam logic [1:0] ENA_LEFT  = 2'b10;

endpackage

// File: rtl/rotate_seq_ctrl_if.sv
// Command and response channels between a bus-side requester and the sequencer.
// Both channels use valid/ready: a transfer happens on a rising edge where
// valid and ready are both high; once valid is raised the payload stays
// stable until that edge, and ready never depends on valid in the same cycle.
interface rotate_seq_ctrl_if #(
    parameter int WIDTH = 100,
    parameter int CNT_W = 7
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_amt;
    logic [WIDTH-1:0] cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             busy;

    modport master (
        output cmd_valid, cmd_dir, cmd_amt, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_amt, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/rotate_seq_ctrl_core.sv
// Circular rotator register: load has priority, ena picks one single-bit step.
module rotate_core
    import rotate_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       ena,
    output logic [WIDTH-1:0] q
);

    // Word register: clear, load, or rotate one bit; ena 2'b11 holds like 2'b00.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= data;
        end else begin
            case (ena)
                ENA_RIGHT: q <= {q[0], q[WIDTH-1:1]};
                ENA_LEFT:  q <= {q[WIDTH-2:0], q[WIDTH-1]};
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/rotate_seq_ctrl.sv
// Command sequencer: loads a word, steps the rotator cmd_amt times, returns it.
module rotate_seq_ctrl
    import rotate_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    rotate_seq_ctrl_if.slave    bus,
    output state_t              state
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             dir_q;
    logic             accept;
    logic             load;
    logic [1:0]       ena;
    logic             cmd_ready_int;
    logic             rsp_valid_int;
    logic [WIDTH-1:0] word;

    assign state         = state_q;
    assign bus.cmd_ready = cmd_ready_int;
    assign bus.rsp_valid = rsp_valid_int;
    assign bus.rsp_data  = word;
    assign bus.busy      = (state_q != IDLE);

    // Next-state and control decode; a zero count skips ROT so the counter never underflows.
    always_comb begin
        state_d       = state_q;
        cmd_ready_int = 1'b0;
        rsp_valid_int = 1'b0;
        accept        = 1'b0;
        load          = 1'b0;
        ena           = ENA_HOLD;
        case (state_q)
            IDLE: begin
                cmd_ready_int = 1'b1;
                if (bus.cmd_valid) begin
                    accept  = 1'b1;
                    load    = 1'b1;
                    state_d = (bus.cmd_amt != '0) ? ROT : DONE;
                end
            end
            ROT: begin
                ena = (dir_q == DIR_LEFT) ? ENA_LEFT : ENA_RIGHT;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                rsp_valid_int = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, step counter and latched direction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= DIR_RIGHT;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q <= bus.cmd_amt;
                dir_q <= bus.cmd_dir;
            end else if (state_q == ROT) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    rotate_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .data  (bus.cmd_data),
        .ena   (ena),
        .q     (word)
    );

endmodule

// File: tb/tb_rotate_seq_ctrl.sv
// Directed bench for rotate_seq_ctrl with hand-computed expected words.
module tb_rotate_seq_ctrl;
    import rotate_pkg::*;

    localparam int W = 100;
    localparam int C = 7;

    logic   clk;
    logic   reset;
    state_t state;
    int     n_checks;
    int     n_pass;
    int     edges;
    int     rot_cycles;
    logic [W-1:0] word_a;
    logic [W-1:0] held;

    rotate_seq_ctrl_if #(.WIDTH(W), .CNT_W(C)) bus ();

    rotate_seq_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .state (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference rotation, one bit per step.
    function automatic logic [W-1:0] rot_ref(input logic [W-1:0] d, input logic dir, input int amt);
        logic [W-1:0] r;
        r = d;
        for (int i = 0; i < amt; i++) begin
            if (dir) r = {r[W-2:0], r[W-1]};
            else     r = {r[0], r[W-1:1]};
        end
        return r;
    endfunction

    // Present a command from IDLE; returns #1 after the accepting edge.
    task automatic send_cmd(input logic dir, input logic [C-1:0] amt, input logic [W-1:0] data);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_dir   = dir;
        bus.cmd_amt   = amt;
        bus.cmd_data  = data;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    // Count edges (accept edge included) until rsp_valid, and ROT cycles seen.
    task automatic wait_rsp(output int n_edges, output int n_rot);
        n_edges = 1;
        n_rot   = 0;
        while (!bus.rsp_valid && n_edges < 1000) begin
            if (state == ROT) n_rot++;
            @(posedge clk);
            #1;
            n_edges++;
        end
        if (!bus.rsp_valid) check("rsp_timeout", {99'b0, bus.rsp_valid}, 100'd1);
    endtask

    // Complete the response handshake and confirm return to IDLE.
    task automatic ack_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        check("idle_after_ack", W'(state), W'(IDLE));
        check("busy_after_ack", W'(bus.busy), 100'd0);
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_dir   = 1'b0;
        bus.cmd_amt   = '0;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", W'(state), W'(IDLE));
        check("rst_cmd_ready", W'(bus.cmd_ready), 100'd1);
        check("rst_rsp_valid", W'(bus.rsp_valid), 100'd0);
        check("rst_busy", W'(bus.busy), 100'd0);
        check("rst_rsp_data", bus.rsp_data, 100'd0);
        reset = 1'b0;

        // Right single step: bit 0 wraps to bit 99.
        send_cmd(DIR_RIGHT, 7'd1, 100'd1);
        check("r1_busy_rot", W'(bus.busy), 100'd1);
        wait_rsp(edges, rot_cycles);
        check("r1_edges", W'(edges), 100'd2);
        check("r1_rot_cycles", W'(rot_cycles), 100'd1);
        check("r1_busy_done", W'(bus.busy), 100'd1);
        check("r1_data", bus.rsp_data, {1'b1, 99'b0});
        ack_rsp();

        // Left three steps then left 99 steps.
        send_cmd(DIR_LEFT, 7'd3, 100'h1);
        wait_rsp(edges, rot_cycles);
        check("l3_edges", W'(edges), 100'd4);
        check("l3_data", bus.rsp_data, 100'h8);
        ack_rsp();
        send_cmd(DIR_LEFT, 7'd99, 100'h8);
        wait_rsp(edges, rot_cycles);
        check("l99_edges", W'(edges), 100'd100);
        check("l99_data", bus.rsp_data, 100'h4);
        ack_rsp();

        // Zero count goes straight to DONE.
        send_cmd(DIR_RIGHT, 7'd0, 100'hABC);
        wait_rsp(edges, rot_cycles);
        check("z_edges", W'(edges), 100'd1);
        check("z_rot_cycles", W'(rot_cycles), 100'd0);
        check("z_data", bus.rsp_data, 100'hABC);
        ack_rsp();

        // Full count returns the original word.
        word_a = {$urandom(), $urandom(), $urandom(), $urandom()};
        send_cmd(DIR_LEFT, 7'd100, word_a);
        wait_rsp(edges, rot_cycles);
        check("full_edges", W'(edges), 100'd101);
        check("full_rot_cycles", W'(rot_cycles), 100'd100);
        check("full_data", bus.rsp_data, word_a);
        ack_rsp();

        // Backpressure in DONE with a pending command.
        send_cmd(DIR_RIGHT, 7'd2, 100'h6);
        wait_rsp(edges, rot_cycles);
        check("bp_data", bus.rsp_data, {2'b10, 98'b0} | 100'h1);
        held = bus.rsp_data;
        bus.cmd_valid = 1'b1;
        bus.cmd_dir   = DIR_RIGHT;
        bus.cmd_amt   = 7'd1;
        bus.cmd_data  = 100'h3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_rsp_valid", W'(bus.rsp_valid), 100'd1);
            check("bp_rsp_data", bus.rsp_data, held);
            check("bp_cmd_ready", W'(bus.cmd_ready), 100'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        check("bp_idle", W'(state), W'(IDLE));
        check("bp_idle_ready", W'(bus.cmd_ready), 100'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        check("bp_next_accept", W'(state), W'(ROT));
        wait_rsp(edges, rot_cycles);
        check("bp_next_data", bus.rsp_data, {1'b1, 99'b0} | 100'h1);
        ack_rsp();

        // Reset in the middle of a 50-step rotation.
        send_cmd(DIR_RIGHT, 7'd50, 100'h1234_5678_9ABC);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        check("mid_still_rot", W'(state), W'(ROT));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid_rst_state", W'(state), W'(IDLE));
        check("mid_rst_ready", W'(bus.cmd_ready), 100'd1);
        check("mid_rst_valid", W'(bus.rsp_valid), 100'd0);
        check("mid_rst_data", bus.rsp_data, 100'd0);
        send_cmd(DIR_LEFT, 7'd2, 100'h5);
        wait_rsp(edges, rot_cycles);
        check("post_rst_edges", W'(edges), 100'd3);
        check("post_rst_data", bus.rsp_data, 100'h14);
        ack_rsp();

        // Back-to-back with cmd_valid held high and rsp_ready high.
        word_a = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_dir   = DIR_RIGHT;
        bus.cmd_amt   = 7'd2;
        bus.cmd_data  = word_a;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("b2b_first_accept", W'(state), W'(ROT));
        bus.cmd_dir  = DIR_LEFT;
        bus.cmd_amt  = 7'd3;
        bus.cmd_data = 100'hF0F;
        wait_rsp(edges, rot_cycles);
        check("b2b_first_data", bus.rsp_data, rot_ref(word_a, DIR_RIGHT, 2));
        @(posedge clk);
        #1;
        check("b2b_hs_idle", W'(state), W'(IDLE));
        check("b2b_hs_ready", W'(bus.cmd_ready), 100'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        check("b2b_second_accept", W'(state), W'(ROT));
        wait_rsp(edges, rot_cycles);
        check("b2b_second_data", bus.rsp_data, rot_ref(100'hF0F, DIR_LEFT, 3));
        check("b2b_second_hand", bus.rsp_data, 100'h7878);
        ack_rsp();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
